// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// The master drives operands and out_ready; the slave returns results and in_ready.
interface addsub_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             op;
    logic             sgn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in1, in2, op, sgn, in_valid, out_ready,
        input  in_ready, out, carry, ovf, out_valid
    );

    modport slave (
        input  in1, in2, op, sgn, in_valid, out_ready,
        output in_ready, out, carry, ovf, out_valid
    );
endinterface

// File: rtl/addsub_pipe.sv
// Two-stage add/subtract pipeline with signed/unsigned flags, optional saturation,
// a whole-pipe stall on output backpressure and a delivered-result counter.
module addsub_pipe #(
    parameter int WIDTH = 8,
    parameter int SAT   = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    addsub_pipe_if.slave     bus,
    output logic [CNT_W-1:0] txn_count
);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic             sgn_q;
    logic             v1;

    logic             stall;
    logic [WIDTH:0]   res;
    logic             sovf;
    logic             c_n;
    logic             o_n;
    logic [WIDTH-1:0] r_n;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    always_comb begin
        res  = op_q ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
        c_n  = res[WIDTH];
        sovf = op_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]))
                    : ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]));
        o_n  = sgn_q ? sovf : c_n;
        r_n  = res[WIDTH-1:0];
        // On signed overflow the true result always carries the sign of in1.
        if ((SAT != 0) && o_n) begin
            if (sgn_q)
                r_n = a_q[WIDTH-1] ? SMIN : SMAX;
            else
                r_n = op_q ? '0 : '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= 1'b0;
            sgn_q         <= 1'b0;
            v1            <= 1'b0;
            bus.out       <= '0;
            bus.carry     <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.out_valid <= 1'b0;
            txn_count     <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready)
                txn_count <= txn_count + 1'b1;
            if (!stall) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    a_q   <= bus.in1;
                    b_q   <= bus.in2;
                    op_q  <= bus.op;
                    sgn_q <= bus.sgn;
                end
                bus.out_valid <= v1;
                if (v1) begin
                    bus.out   <= r_n;
                    bus.carry <= c_n;
                    bus.ovf   <= o_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench: a wrap-mode DUT (4-bit counter) and a saturating DUT run in lockstep
// against an integer-arithmetic reference model.
module tb_addsub_pipe;
    typedef struct {
        logic [7:0] ow;
        logic [7:0] os;
        logic       c;
        logic       o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  a_d = '0;
    logic [7:0]  b_d = '0;
    logic        op_d = 1'b0;
    logic        sgn_d = 1'b0;
    logic        iv_d = 1'b0;
    logic        ordy = 1'b1;
    logic        rnd_rdy = 1'b0;
    logic [3:0]  cnt_out_w;
    logic [15:0] cnt_out_s;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cw = 0;
    int   cs = 0;
    exp_t qw[$];
    exp_t qs[$];
    exp_t ew;
    exp_t es;

    always #5 clk = ~clk;

    addsub_pipe_if #(.WIDTH(8)) ifw ();
    addsub_pipe_if #(.WIDTH(8)) ifs ();

    assign ifw.in1 = a_d;  assign ifs.in1 = a_d;
    assign ifw.in2 = b_d;  assign ifs.in2 = b_d;
    assign ifw.op = op_d;  assign ifs.op = op_d;
    assign ifw.sgn = sgn_d; assign ifs.sgn = sgn_d;
    assign ifw.in_valid = iv_d; assign ifs.in_valid = iv_d;
    assign ifw.out_ready = ordy; assign ifs.out_ready = ordy;

    addsub_pipe #(.WIDTH(8), .SAT(0), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .bus(ifw), .txn_count(cnt_out_w)
    );
    addsub_pipe #(.WIDTH(8), .SAT(1), .CNT_W(16)) dut_s (
        .clk(clk), .rst(rst), .bus(ifs), .txn_count(cnt_out_s)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference: plain integer arithmetic on the mathematical values of the operands.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic op, input logic sgn);
        exp_t   e;
        longint ua, ub, sa, sb, uraw, tru;
        logic   sov;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua >= 128) ? ua - 256 : ua;
        sb   = (ub >= 128) ? ub - 256 : ub;
        uraw = op ? ua - ub : ua + ub;
        tru  = op ? sa - sb : sa + sb;
        e.c  = op ? (ua < ub) : (uraw > 255);
        sov  = (tru > 127) || (tru < -128);
        e.o  = sgn ? sov : e.c;
        e.ow = 8'(uraw & 255);
        if (!e.o)       e.os = e.ow;
        else if (!sgn)  e.os = op ? 8'd0 : 8'd255;
        else            e.os = (tru > 0) ? 8'h7F : 8'h80;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("cnt_w", cnt_out_w, cw);
            check("in_ready_s", ifs.in_ready, ifw.in_ready);
            if (ifw.out_valid) begin
                if (qw.size() == 0) check("unexpected_w", ifw.out_valid, 0);
                else begin
                    ew = qw[0];
                    check("out_w", ifw.out, ew.ow);
                    check("carry_w", ifw.carry, ew.c);
                    check("ovf_w", ifw.ovf, ew.o);
                    if (ordy) begin
                        void'(qw.pop_front());
                        cw = (cw + 1) % 16;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("cnt_s", cnt_out_s, cs);
            if (ifs.out_valid) begin
                if (qs.size() == 0) check("unexpected_s", ifs.out_valid, 0);
                else begin
                    es = qs[0];
                    check("out_s", ifs.out, es.os);
                    check("carry_s", ifs.carry, es.c);
                    check("ovf_s", ifs.ovf, es.o);
                    if (ordy) begin
                        void'(qs.pop_front());
                        cs = (cs + 1) % 65536;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) ordy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and finish 1 time unit after a rising edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic o, input logic s);
        int unsigned waitc = 0;
        bit done = 0;
        exp_t e;
        a_d = a; b_d = b; op_d = o; sgn_d = s; iv_d = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (ifw.in_ready && rst) begin
                e = model(a, b, o, s);
                qw.push_back(e);
                qs.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waitc++;
                if (waitc > 100) begin
                    bound_fail("send_timeout");
                    done = 1;
                end
            end
        end
        iv_d = 1'b0;
    endtask

    task automatic idle(input int n);
        iv_d = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        qw.delete();
        qs.delete();
        cw = 0;
        cs = 0;
    endtask

    task automatic drain();
        int unsigned waitc = 0;
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;
        ordy = 1'b1;
        while ((qw.size() != 0 || qs.size() != 0) && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        if (qw.size() != 0 || qs.size() != 0) bound_fail("drain_timeout");
    endtask

    task automatic lat_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic o, input logic s, input logic [7:0] xw,
                           input logic [7:0] xs, input logic xc, input logic xo);
        ordy = 1'b1;
        send(a, b, o, s);
        @(negedge clk);
        check({name, "_lat1"}, ifw.out_valid, 0);
        @(negedge clk);
        check({name, "_lat2"}, ifw.out_valid, 1);
        check({name, "_out_w"}, ifw.out, xw);
        check({name, "_out_s"}, ifs.out, xs);
        check({name, "_carry"}, ifw.carry, xc);
        check({name, "_ovf"}, ifw.ovf, xo);
        @(negedge clk);
        check({name, "_after"}, ifw.out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] edge_vals [4] = '{8'd0, 8'd127, 8'd128, 8'd255};

    function automatic logic [7:0] pick();
        if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 3)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        // Reset with an input presented: it must not be accepted.
        a_d = 8'd55; b_d = 8'd66; iv_d = 1'b1; ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", ifw.out_valid, 0);
        check("rst_out", ifw.out, 0);
        check("rst_carry", ifw.carry, 0);
        check("rst_ovf", ifw.ovf, 0);
        check("rst_in_ready", ifw.in_ready, 1);
        check("rst_cnt_w", cnt_out_w, 0);
        check("rst_cnt_s", cnt_out_s, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        iv_d = 1'b0;
        idle(3);

        lat_vec("uadd", 8'd200, 8'd100, 1'b0, 1'b0, 8'd44, 8'd255, 1'b1, 1'b1);
        check("uadd_cnt", cnt_out_w, 1);
        lat_vec("usub", 8'd5, 8'd10, 1'b1, 1'b0, 8'd251, 8'd0, 1'b1, 1'b1);
        lat_vec("sadd", 8'd100, 8'd50, 1'b0, 1'b1, 8'h96, 8'h7F, 1'b0, 1'b1);
        lat_vec("ssub", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 8'h80, 1'b0, 1'b1);

        // Backpressure: results held while out_ready=0, then stream out one per cycle.
        ordy = 1'b0;
        fork
            begin
                send(8'd1, 8'd1, 1'b0, 1'b0);
                send(8'd2, 8'd2, 1'b0, 1'b0);
                send(8'd3, 8'd3, 1'b0, 1'b0);
                send(8'd4, 8'd4, 1'b0, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                check("bp_in_ready", ifw.in_ready, 0);
                check("bp_hold_w", ifw.out, 2);
                check("bp_hold_s", ifs.out, 2);
                ordy = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_stream", ifw.out_valid, 1);
                end
            end
        join
        idle(3);

        // Mid-flight reset discards in-flight work.
        ordy = 1'b1;
        send(8'd10, 8'd20, 1'b0, 1'b0);
        send(8'd7, 8'd3, 1'b1, 1'b0);
        do_reset();
        idle(4);
        check("mid_rst_cnt_w", cnt_out_w, 0);
        check("mid_rst_cnt_s", cnt_out_s, 0);
        lat_vec("post_rst", 8'd9, 8'd9, 1'b0, 1'b0, 8'd18, 8'd18, 1'b0, 1'b0);

        // 16 more deliveries: the 4-bit counter passes 15 -> 0 -> 1.
        for (int i = 0; i < 16; i++) send(8'(i), 8'd1, 1'b0, 1'b0);
        drain();
        idle(2);
        check("wrap_cnt_w", cnt_out_w, 1);
        check("wrap_cnt_s", cnt_out_s, 17);

        // Randomized traffic with random backpressure and bubbles.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        drain();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
